// File: rtl/voice_pkg.sv
// Constants and state type shared by the PDM sampler and the record/playback controller.
package voice_pkg;

  localparam int SAMPLE_FREQ       = 10_000;
  localparam int PDM_CLK_FREQ      = 2_400_000;
  localparam int CLOCKS_PER_SAMPLE = PDM_CLK_FREQ / SAMPLE_FREQ;
  localparam int SAMPLES_PER_WORD  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } voice_state_t;

endpackage

// File: rtl/play_unpacker.sv
// Playback pacing: splits RAM words into samples, one every clocks_per_sample clocks,
// with a one-word holding register so the next word is fetched during the last byte.
module play_unpacker
  import voice_pkg::*;
#(
  parameter int sample_w          = 8,
  parameter int clocks_per_sample = CLOCKS_PER_SAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rd_issued,
  input  logic [4*sample_w-1:0] rdata,
  output logic [sample_w-1:0]   play_sample,
  output logic                  play_valid,
  output logic                  prefetch_req,
  output logic                  done
);

  localparam int word_w  = SAMPLES_PER_WORD * sample_w;
  localparam int timer_w = $clog2(clocks_per_sample);
  localparam logic [timer_w-1:0] timer_max = timer_w'(clocks_per_sample - 1);

  logic [timer_w-1:0] timer_q;
  logic [1:0]         idx_q;
  logic [word_w-1:0]  cur_q;
  logic [word_w-1:0]  hold_q;
  logic               hold_v_q;
  logic               active_q;
  logic               rd_valid_q;
  logic               tc;
  logic               emit_cur;
  logic               emit_hold;

  // idx_q is the next byte of cur_q to emit; 0 means the current word is used up
  assign tc           = active_q && (timer_q == '0);
  assign emit_cur     = tc && (idx_q != 2'd0);
  assign emit_hold    = tc && (idx_q == 2'd0) && hold_v_q;
  assign done         = tc && (idx_q == 2'd0) && !hold_v_q;
  assign prefetch_req = emit_cur && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q     <= '0;
      idx_q       <= '0;
      cur_q       <= '0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      active_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      play_sample <= '0;
      play_valid  <= 1'b0;
    end else if (clear) begin
      timer_q    <= '0;
      idx_q      <= '0;
      hold_v_q   <= 1'b0;
      active_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      play_valid <= 1'b0;
    end else begin
      play_valid <= 1'b0;
      rd_valid_q <= rd_issued;

      if (active_q) begin
        timer_q <= tc ? timer_max : timer_q - 1'b1;
      end

      // First word goes straight out; later words wait in the holding register
      if (rd_valid_q && !active_q) begin
        play_sample <= rdata[word_w-1 -: sample_w];
        play_valid  <= 1'b1;
        cur_q       <= rdata << sample_w;
        idx_q       <= 2'd1;
        timer_q     <= timer_max;
        active_q    <= 1'b1;
      end else if (rd_valid_q) begin
        hold_q   <= rdata;
        hold_v_q <= 1'b1;
      end

      if (emit_cur) begin
        play_sample <= cur_q[word_w-1 -: sample_w];
        play_valid  <= 1'b1;
        cur_q       <= cur_q << sample_w;
        idx_q       <= idx_q + 2'd1;
      end

      if (emit_hold) begin
        play_sample <= hold_q[word_w-1 -: sample_w];
        play_valid  <= 1'b1;
        cur_q       <= hold_q << sample_w;
        idx_q       <= 2'd1;
        hold_v_q    <= 1'b0;
      end

      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/voice_rec_ctrl.sv
// Record/playback controller between the PDM sampler and the sample RAM.
//   state     | meaning
//   ST_IDLE   | waiting for rec_start / play_start
//   ST_RECORD | sampler enabled, each sampler word written at the next address
//   ST_PLAY   | words read back from address 0 and paced out by play_unpacker
module voice_rec_ctrl
  import voice_pkg::*;
#(
  parameter int addr_w            = 14,
  parameter int sample_w          = 8,
  parameter int clocks_per_sample = CLOCKS_PER_SAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_start,
  input  logic                  rec_stop,
  input  logic                  play_start,
  input  logic                  play_stop,
  input  logic [4*sample_w-1:0] ram_data,
  input  logic                  ram_wr,
  output logic                  count_en,
  output logic [addr_w-1:0]     mem_addr,
  output logic [4*sample_w-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [4*sample_w-1:0] mem_rdata,
  output logic [sample_w-1:0]   play_sample,
  output logic                  play_valid,
  output logic [addr_w:0]       rec_len,
  output logic                  busy
);

  localparam logic [addr_w-1:0] last_addr = '1;

  voice_state_t      state_q;
  voice_state_t      state_d;
  logic [addr_w-1:0] wr_addr_q;
  logic [addr_w:0]   rd_addr_q;
  logic              start_rec;
  logic              start_play;
  logic              wr_word;
  logic              read_next;
  logic              unp_clear;
  logic              pf_req;
  logic              play_done;

  always_comb begin
    state_d    = state_q;
    start_rec  = 1'b0;
    start_play = 1'b0;
    wr_word    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rec_start) begin
          state_d   = ST_RECORD;
          start_rec = 1'b1;
        end else if (play_start && (rec_len != '0)) begin
          state_d    = ST_PLAY;
          start_play = 1'b1;
        end
      end
      ST_RECORD: begin
        wr_word = ram_wr;
        if (rec_stop || (ram_wr && (wr_addr_q == last_addr))) begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (play_stop || play_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A prefetch beyond the recorded length is simply not issued; the unpacker then ends playback
  assign read_next = (state_q == ST_PLAY) && !play_stop && pf_req && (rd_addr_q != rec_len);
  assign unp_clear = (state_q != ST_PLAY) || play_stop;
  assign count_en  = (state_q == ST_RECORD);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rec_len   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;

      if (start_rec) begin
        wr_addr_q <= '0;
        rec_len   <= '0;
      end

      if (wr_word) begin
        mem_we    <= 1'b1;
        mem_wdata <= ram_data;
        mem_addr  <= wr_addr_q;
        wr_addr_q <= wr_addr_q + 1'b1;
        rec_len   <= rec_len + 1'b1;
      end

      if (start_play) begin
        mem_re    <= 1'b1;
        mem_addr  <= '0;
        rd_addr_q <= {{addr_w{1'b0}}, 1'b1};
      end

      if (read_next) begin
        mem_re    <= 1'b1;
        mem_addr  <= rd_addr_q[addr_w-1:0];
        rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  play_unpacker #(
    .sample_w          (sample_w),
    .clocks_per_sample (clocks_per_sample)
  ) u_unpacker (
    .clk          (clk),
    .rst          (rst),
    .clear        (unp_clear),
    .rd_issued    (mem_re),
    .rdata        (mem_rdata),
    .play_sample  (play_sample),
    .play_valid   (play_valid),
    .prefetch_req (pf_req),
    .done         (play_done)
  );

endmodule

// File: tb/tb_voice_rec_ctrl.sv
// Bench for voice_rec_ctrl: event-schedule model checked every cycle plus directed literal checks.
module tb_voice_rec_ctrl;

  localparam int AW  = 14;
  localparam int AWS = 2;
  localparam int SW  = 8;
  localparam int CPS = 240;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          rec_start = 1'b0, rec_stop = 1'b0, play_start = 1'b0, play_stop = 1'b0;
  logic [31:0]   ram_data = '0;
  logic          ram_wr = 1'b0;
  logic          count_en, mem_we, mem_re, play_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [7:0]    play_sample;
  logic [AW:0]   rec_len;

  logic           s_rec_start = 1'b0, s_rec_stop = 1'b0, s_ram_wr = 1'b0;
  logic           s_play_start = 1'b0, s_play_stop = 1'b0;
  logic [31:0]    s_ram_data = '0;
  logic [31:0]    s_mem_rdata = '0;
  logic           s_count_en, s_mem_we, s_mem_re, s_play_valid, s_busy;
  logic [AWS-1:0] s_mem_addr;
  logic [31:0]    s_mem_wdata;
  logic [7:0]     s_play_sample;
  logic [AWS:0]   s_rec_len;

  voice_rec_ctrl #(.addr_w(AW), .sample_w(SW), .clocks_per_sample(CPS)) dut (
    .clk(clk), .rst(rst), .rec_start(rec_start), .rec_stop(rec_stop),
    .play_start(play_start), .play_stop(play_stop), .ram_data(ram_data), .ram_wr(ram_wr),
    .count_en(count_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .play_sample(play_sample),
    .play_valid(play_valid), .rec_len(rec_len), .busy(busy)
  );

  voice_rec_ctrl #(.addr_w(AWS), .sample_w(SW), .clocks_per_sample(CPS)) dut_small (
    .clk(clk), .rst(rst), .rec_start(s_rec_start), .rec_stop(s_rec_stop),
    .play_start(s_play_start), .play_stop(s_play_stop), .ram_data(s_ram_data), .ram_wr(s_ram_wr),
    .count_en(s_count_en), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
    .mem_re(s_mem_re), .mem_rdata(s_mem_rdata), .play_sample(s_play_sample),
    .play_valid(s_play_valid), .rec_len(s_rec_len), .busy(s_busy)
  );

  always #5 clk = ~clk;

  // Sample RAM: synchronous write, read data valid the cycle after mem_re
  logic [31:0] ram [0:CAP-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: expected events keyed by cycle number (cycle n = interval after posedge n)
  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { int c; int addr; logic [31:0] data; } log_t;

  wr_t         exp_wr [int];
  logic [7:0]  exp_pv [int];
  bit          exp_re [int];
  logic [31:0] m_words [$];
  int          m_mode = 0;      // 0 idle, 1 record, 2 play
  int          m_play_end = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0;
      m_words.delete();
      exp_wr.delete();
      exp_pv.delete();
      exp_re.delete();
    end else begin
      cyc = cyc + 1;
      case (m_mode)
        0: begin
          if (rec_start) begin
            m_mode = 1;
            m_words.delete();
          end else if (play_start && m_words.size() > 0) begin
            m_mode = 2;
            exp_re[cyc] = 1'b1;
            foreach (m_words[w])
              for (int b = 0; b < 4; b++)
                exp_pv[cyc + 2 + CPS * (4 * w + b)] = m_words[w][31 - 8 * b -: 8];
            m_play_end = cyc + 2 + CPS * 4 * m_words.size();
          end
        end
        1: begin
          if (ram_wr) begin
            exp_wr[cyc] = '{m_words.size(), ram_data};
            m_words.push_back(ram_data);
          end
          if (rec_stop || m_words.size() == CAP) m_mode = 0;
        end
        default: begin
          if (play_stop) begin
            int keys [$];
            foreach (exp_pv[k]) if (k >= cyc) keys.push_back(k);
            foreach (keys[i]) exp_pv.delete(keys[i]);
            m_mode = 0;
          end else if (cyc == m_play_end) begin
            m_mode = 0;
          end
        end
      endcase
    end
  end

  int   pv_cyc [$];
  logic [7:0] pv_val [$];
  log_t wr_log [$];
  log_t s_log [$];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", busy, m_mode != 0);
      chk("count_en", count_en, m_mode == 1);
      chk("rec_len", rec_len, m_words.size());
      chk("mem_we", mem_we, exp_wr.exists(cyc));
      if (exp_wr.exists(cyc)) begin
        chk("mem_addr_wr", mem_addr, exp_wr[cyc].addr);
        chk("mem_wdata", mem_wdata, exp_wr[cyc].data);
      end
      if (m_mode != 2) chk("mem_re_idle", mem_re, 0);
      if (exp_re.exists(cyc)) begin
        chk("mem_re_first", mem_re, 1);
        chk("mem_addr_first", mem_addr, 0);
      end
      chk("we_re_excl", mem_we & mem_re, 0);
      chk("play_valid", play_valid, exp_pv.exists(cyc));
      if (exp_pv.exists(cyc)) chk("play_sample", play_sample, exp_pv[cyc]);
    end
    if (play_valid) begin
      pv_cyc.push_back(cyc);
      pv_val.push_back(play_sample);
    end
    if (mem_we) wr_log.push_back('{cyc, int'(mem_addr), mem_wdata});
    if (s_mem_we) s_log.push_back('{cyc, int'(s_mem_addr), s_mem_wdata});
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] t2_data [3];
  int          t2_cyc [3];
  int          s0, fall;

  initial begin
    t2_data[0] = 32'h01020304;
    t2_data[1] = 32'h05060708;
    t2_data[2] = 32'h090A0B0C;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_count_en", count_en, 0);
    chk("rst_rec_len", rec_len, 0);
    chk("rst_play_valid", play_valid, 0);
    step();
    rst = 1'b0;
    step(2);

    // Reset in the middle of a recording
    rec_start = 1'b1; step(); rec_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ram_wr = 1'b1; ram_data = 32'hDEAD0000 + i; step();
      ram_wr = 1'b0;
      if (i < 2) step();
    end
    chk("t1_we_before_rst", mem_we, 1);
    chk("t1_len_before_rst", rec_len, 3);
    rst = 1'b1;
    #1;
    chk("t1_async_we", mem_we, 0);
    chk("t1_async_addr", mem_addr, 0);
    chk("t1_async_wdata", mem_wdata, 0);
    chk("t1_async_count_en", count_en, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_rec_len", rec_len, 0);
    step();
    rst = 1'b0;
    step(2);
    play_start = 1'b1; step(); play_start = 1'b0;
    step(3);
    chk("t1_play_ignored", busy, 0);

    // Three-word recording
    wr_log.delete();
    rec_start = 1'b1; step(); rec_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ram_wr = 1'b1; ram_data = t2_data[i]; step();
      t2_cyc[i] = cyc;
      ram_wr = 1'b0; step(2);
    end
    rec_stop = 1'b1; step(); rec_stop = 1'b0;
    step(2);
    chk("t2_nwrites", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      chk("t2_wr_addr", wr_log[i].addr, i);
      chk("t2_wr_data", wr_log[i].data, t2_data[i]);
      chk("t2_wr_latency", wr_log[i].c - t2_cyc[i], 0);
    end
    chk("t2_rec_len", rec_len, 3);
    chk("t2_count_en_off", count_en, 0);

    // Play it back
    pv_cyc.delete(); pv_val.delete();
    play_start = 1'b1; step(); play_start = 1'b0;
    s0 = cyc;
    for (int i = 0; i < 4000 && busy; i++) step();
    fall = cyc;
    chk("t3_busy_fall_timeout", busy, 0);
    chk("t3_npulses", pv_cyc.size(), 12);
    if (pv_cyc.size() > 0) chk("t3_first_latency", pv_cyc[0] - (s0 - 1), 3);
    for (int i = 1; i < pv_cyc.size(); i++) chk("t3_spacing", pv_cyc[i] - pv_cyc[i-1], 240);
    for (int i = 0; i < pv_val.size(); i++) chk("t3_value", pv_val[i], i + 1);
    if (pv_cyc.size() > 0) chk("t3_busy_after_last", fall - pv_cyc[pv_cyc.size()-1], 240);

    // rec_stop coincident with ram_wr
    wr_log.delete();
    rec_start = 1'b1; step(); rec_start = 1'b0;
    ram_wr = 1'b1; ram_data = 32'h11223344; step(); ram_wr = 1'b0;
    step();
    ram_wr = 1'b1; ram_data = 32'h55667788; rec_stop = 1'b1; step();
    ram_wr = 1'b0; rec_stop = 1'b0;
    step(2);
    chk("t4_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t4_last_addr", wr_log[1].addr, 1);
      chk("t4_last_data", wr_log[1].data, 32'h55667788);
    end
    chk("t4_rec_len", rec_len, 2);
    chk("t4_idle", busy, 0);

    // play_stop after five samples
    pv_cyc.delete(); pv_val.delete();
    play_start = 1'b1; step(); play_start = 1'b0;
    for (int i = 0; i < 2000 && pv_val.size() < 5; i++) step();
    play_stop = 1'b1; step(); play_stop = 1'b0;
    step(600);
    chk("t5_npulses", pv_val.size(), 5);
    for (int i = 0; i < pv_val.size(); i++) chk("t5_value", pv_val[i], 8'h11 * (i + 1));
    chk("t5_idle", busy, 0);

    // Simultaneous starts (record wins), play_* ignored while recording, empty recording
    rec_start = 1'b1; play_start = 1'b1; step(); rec_start = 1'b0; play_start = 1'b0;
    chk("t5_record_wins", count_en, 1);
    play_start = 1'b1; step(); play_start = 1'b0;
    play_stop = 1'b1; step(); play_stop = 1'b0;
    chk("t5_still_recording", count_en, 1);
    rec_stop = 1'b1; step(); rec_stop = 1'b0;
    step();
    chk("t5_empty_len", rec_len, 0);
    play_start = 1'b1; step(); play_start = 1'b0;
    step(3);
    chk("t5_empty_play_ignored", busy, 0);

    // Small RAM: auto-stop when full
    s_log.delete();
    s_rec_start = 1'b1; step(); s_rec_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_ram_wr = 1'b1; s_ram_data = 32'hA0A0A000 + i; step();
      if (i == 2) chk("t6_count_en_mid", s_count_en, 1);
      if (i == 3) chk("t6_count_en_full", s_count_en, 0);
    end
    s_ram_wr = 1'b0;
    step(3);
    chk("t6_nwrites", s_log.size(), 4);
    for (int i = 0; i < s_log.size(); i++) begin
      chk("t6_wr_addr", s_log[i].addr, i);
      chk("t6_wr_data", s_log[i].data, 32'hA0A0A000 + i);
    end
    chk("t6_rec_len", s_rec_len, 4);
    chk("t6_idle", s_busy, 0);
    chk("t6_no_read", s_mem_re, 0);
    chk("t6_no_play", {s_play_valid, s_play_sample}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_rec_ctrl.md
# voice_rec_ctrl

Record/playback controller sitting directly downstream of the PDM sampler in the voice path. In record mode it enables the sampler and writes each packed 32-bit word it produces into a single-port sample RAM at incrementing addresses. In play mode it reads the words back, unpacks them into 8-bit samples and emits one sample per sample period to the audio output stage. It runs on the same 2.4 MHz clock as the sampler.

## Interface
Parameters:
- addr_w, 14, sample RAM address width; capacity 2**addr_w words
- sample_w, 8, bits per sample; word width is 4*sample_w
- clocks_per_sample, 240, clocks between played samples (2.4 MHz / 10 kHz)

Ports:
- clk  in  1  2.4 MHz clock; the block's only clock
- rst  in  1  reset, asynchronous, active-high
- rec_start  in  1  one-cycle pulse, begin recording
- rec_stop  in  1  one-cycle pulse, end recording
- play_start  in  1  one-cycle pulse, begin playback
- play_stop  in  1  one-cycle pulse, abort playback
- ram_data  in  4*sample_w  packed word from sampler; oldest sample in MSBs
- ram_wr  in  1  sampler word-valid strobe
- count_en  out  1  sampler enable; high only in RECORD
- mem_addr  out  addr_w  RAM address
- mem_wdata  out  4*sample_w  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable; mem_rdata valid the following cycle
- mem_rdata  in  4*sample_w  RAM read data
- play_sample  out  sample_w  current playback sample
- play_valid  out  1  one-cycle pulse when play_sample updates
- rec_len  out  addr_w+1  words stored by the last recording
- busy  out  1  high when not IDLE

## Operation
- States: IDLE, RECORD, PLAY.
- IDLE: rec_start -> RECORD, write address cleared. play_start with rec_len!=0 -> PLAY; with rec_len==0 ignored. Simultaneous rec_start and play_start: record wins.
- RECORD: count_en=1. Each ram_wr registers mem_we=1, mem_wdata=ram_data, mem_addr=write address; address increments. rec_len tracks words written. rec_stop -> IDLE; ram_wr in the same cycle is still written. Address 2**addr_w-1 written -> IDLE (full), rec_len=2**addr_w. Partial sampler word at stop is discarded. play_* ignored.
- PLAY: words read from address 0 to rec_len-1. Each word emits bytes [31:24], [23:16], [15:8], [7:0] in that order. Next word prefetched into a holding register while the 4th byte of the current word is emitted, so spacing stays exactly clocks_per_sample. After the last byte's period elapses -> IDLE. play_stop -> IDLE next edge; no further play_valid. rec_* ignored.
- Start pulses arriving outside IDLE are dropped, not queued.
- Reset, including mid-operation: state IDLE; all outputs 0; rec_len 0; RAM contents untouched but unreachable.

## Timing
- Record: ram_wr high in cycle t -> mem_we high in cycle t+1 only, with the captured data and address. Full or stop at edge t+1 -> count_en low from cycle t+1.
- rec_start sampled at edge t -> count_en high from cycle t+1.
- Play: play_start sampled at edge t -> mem_re=1, mem_addr=0 in cycle t+1. rdata captured at edge t+2. First play_valid in cycle t+3. Subsequent pulses every clocks_per_sample cycles.
- mem_we and mem_re are never high in the same cycle.
- Sample timer width: $clog2(clocks_per_sample); wraps at clocks_per_sample-1.

## Structure
- Shared package voice_pkg: state enum, SAMPLE_FREQ (10000), PDM clock (2_400_000), derived CLOCKS_PER_SAMPLE; the sampler uses the same constants.
- Sub-module play_unpacker: sample timer, byte index, holding register, prefetch request, play_sample/play_valid generation. The top holds the FSM, address counter, RAM mux and rec_len.

## Test plan
- Reset mid-RECORD after 3 words -> all outputs 0 asynchronously; rec_len=0; later play_start ignored.
- rec_start, 3 ram_wr with 0x01020304, 0x05060708, 0x090A0B0C, rec_stop -> writes to addresses 0,1,2 one cycle after each strobe; rec_len=3; count_en low after stop.
- Play that recording -> 12 play_valid pulses exactly 240 cycles apart, first 3 cycles after play_start; values 0x01..0x0C in order; busy falls 240 cycles after the last pulse.
- addr_w=2, 5 ram_wr strobes -> 4 writes, auto-stop after address 3, rec_len=4, 5th strobe ignored.
- rec_stop coincident with ram_wr -> that word written; rec_len includes it.
- play_stop after 5 samples -> no further play_valid; play_start with rec_len=0 -> stays IDLE.
